// File: rtl/color_proc_sched.sv
// -----------------------------------------------------------------------------
// color_proc_sched
//
// Frame-level sequencer for the per-pixel colour-filter datapath.
// A camera frame-complete pulse (frame_start) launches one sweep of the
// original-image RAM. Every read address is carried down a c_rd_lat-deep
// (valid, address) pipeline, so the processed-image write lands exactly when
// the RAM read data (passed through the combinational filter) becomes valid.
// Starts that arrive while a frame is in flight are flagged as overruns and
// collapse into a single pending start that is served right after DONE.
//
// Ports:
//   clk           in   FPGA clock
//   rst           in   synchronous active-high reset
//   enable        in   new starts accepted only while high
//   frame_start   in   one-cycle pulse: original frame is complete
//   rgbfilter_in  in   [2:0] requested filter selection
//   rgbfilter     out  [2:0] filter applied to the current frame
//   orig_addr     out  [c_nb_img_pxls-1:0] original-image read address
//   proc_addr     out  [c_nb_img_pxls-1:0] processed-image write address
//   proc_we       out  processed-image write enable
//   busy          out  high from RUN through DONE inclusive
//   frame_done    out  one-cycle pulse after the last write
//   overrun       out  one-cycle pulse when a start arrives while busy
//
// Parameters:
//   c_img_pxls     pixels per frame
//   c_nb_img_pxls  address width, 2**c_nb_img_pxls >= c_img_pxls
//   c_rd_lat       original-image RAM read latency, 1..4
// -----------------------------------------------------------------------------
module color_proc_sched #(
  parameter int c_img_pxls    = 4800,
  parameter int c_nb_img_pxls = 13,
  parameter int c_rd_lat      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic [2:0]               rgbfilter_in,
  output logic [2:0]               rgbfilter,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  output logic [c_nb_img_pxls-1:0] proc_addr,
  output logic                     proc_we,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);

  state_t                   state_q, state_d;
  logic [c_nb_img_pxls-1:0] cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [2:0]               rgbfilter_q, rgbfilter_d;

  // Read-latency pipeline: stage 0 is the newest entry, stage c_rd_lat-1
  // is the one whose read data is available now and drives the write port.
  logic                     pipe_vld_q  [c_rd_lat];
  logic                     pipe_vld_d  [c_rd_lat];
  logic [c_nb_img_pxls-1:0] pipe_addr_q [c_rd_lat];
  logic [c_nb_img_pxls-1:0] pipe_addr_d [c_rd_lat];

  logic start_req;
  logic busy_w;
  logic pipe_drained;

  assign start_req = frame_start & enable;
  assign busy_w    = (state_q != ST_IDLE);

  // The pipeline is about to be empty when nothing but the output stage
  // still holds a valid entry: that entry is the last write of the frame,
  // performed in the current cycle.
  always_comb begin
    pipe_drained = 1'b1;
    for (int i = 0; i < c_rd_lat - 1; i++) begin
      if (pipe_vld_q[i]) begin
        pipe_drained = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    rgbfilter_d = rgbfilter_q;

    case (state_q)
      ST_IDLE: begin
        if (start_req || pending_q) begin
          rgbfilter_d = rgbfilter_in;
          cnt_d       = '0;
          pending_d   = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        // The counter parks on the last address rather than wrapping.
        if (cnt_q == c_last_addr) begin
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (pipe_drained) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any accepted start while busy (including the DONE cycle) is remembered
    // once; IDLE never sees busy_w, so this cannot fight the clear above.
    if (busy_w && start_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      rgbfilter_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      rgbfilter_q <= rgbfilter_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-latency compensation pipeline
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < c_rd_lat; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // A read is issued in every RUN cycle, including the last address.
        assign pipe_vld_d[gi]  = (state_q == ST_RUN);
        assign pipe_addr_d[gi] = cnt_q;
      end else begin : g_tail
        assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
        assign pipe_addr_d[gi] = pipe_addr_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_vld_q[gi]  <= 1'b0;
          pipe_addr_q[gi] <= '0;
        end else begin
          pipe_vld_q[gi]  <= pipe_vld_d[gi];
          pipe_addr_q[gi] <= pipe_addr_d[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rgbfilter  = rgbfilter_q;
  assign orig_addr  = cnt_q;
  assign proc_addr  = pipe_addr_q[c_rd_lat-1];
  assign proc_we    = pipe_vld_q[c_rd_lat-1];
  assign busy       = busy_w;
  assign frame_done = (state_q == ST_DONE);
  // Same-cycle indication of a start that lands on a busy sequencer.
  assign overrun    = start_req & busy_w;

endmodule

// File: tb/tb_color_proc_sched.sv
// -----------------------------------------------------------------------------
// tb_color_proc_sched
//
// Two sequencers (16-pixel frames, read latency 1 and 3) share one stimulus
// stream. A frame-position model predicts every output from the position of
// the current cycle within the frame; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_color_proc_sched;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, enable, frame_start;
  logic [2:0] rgbfilter_in;

  logic [2:0] rgb_a, rgb_b;
  logic [3:0] oa_a, oa_b, pa_a, pa_b;
  logic       we_a, we_b, bs_a, bs_b, dn_a, dn_b, ov_a, ov_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  color_proc_sched #(.c_img_pxls(N), .c_nb_img_pxls(4), .c_rd_lat(1)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .rgbfilter_in(rgbfilter_in), .rgbfilter(rgb_a), .orig_addr(oa_a),
    .proc_addr(pa_a), .proc_we(we_a), .busy(bs_a), .frame_done(dn_a),
    .overrun(ov_a)
  );

  color_proc_sched #(.c_img_pxls(N), .c_nb_img_pxls(4), .c_rd_lat(3)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .rgbfilter_in(rgbfilter_in), .rgbfilter(rgb_b), .orig_addr(oa_b),
    .proc_addr(pa_b), .proc_we(we_b), .busy(bs_b), .frame_done(dn_b),
    .overrun(ov_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model: mk = position of the current cycle in the frame
  // (0 = idle, 1 = first read cycle, N+L+1 = done cycle).
  // ---------------------------------------------------------------------------
  int       lat [2] = '{1, 3};
  int       mk [2];
  bit       mpend [2];
  int       mfilt [2];
  int       morig [2];
  bit       mvalid = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mk[i] = 0; mpend[i] = 1'b0; mfilt[i] = 0; morig[i] = 0;
        mvalid = 1'b1;
      end else if (mvalid) begin
        if (mk[i] > 0) begin
          if (frame_start && enable) mpend[i] = 1'b1;
          if (mk[i] == N + lat[i] + 1) mk[i] = 0;
          else mk[i] = mk[i] + 1;
        end else if ((frame_start && enable) || mpend[i]) begin
          mk[i] = 1; mfilt[i] = int'(rgbfilter_in); mpend[i] = 1'b0;
        end
        if (mk[i] >= 1 && mk[i] <= N) morig[i] = mk[i] - 1;
      end
    end
  end

  task automatic chk(input string name, input int i, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%0d expected=%0d", name, i, cyc, got, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [2:0] rgb, input logic [3:0] oa,
                          input logic [3:0] pa, input logic we, input logic bs,
                          input logic dn, input logic ov);
    int k, l;
    bit exp_we;
    k = mk[i];
    l = lat[i];
    exp_we = (k >= l + 1) && (k <= N + l);
    chk("busy", i, int'(bs), int'(k > 0));
    chk("proc_we", i, int'(we), int'(exp_we));
    chk("frame_done", i, int'(dn), int'(k == N + l + 1));
    chk("overrun", i, int'(ov), int'(frame_start && enable && (k > 0)));
    chk("rgbfilter", i, int'(rgb), mfilt[i]);
    chk("orig_addr", i, int'(oa), morig[i]);
    if (exp_we) chk("proc_addr", i, int'(pa), k - l - 1);
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp_inst(0, rgb_a, oa_a, pa_a, we_a, bs_a, dn_a, ov_a);
      cmp_inst(1, rgb_b, oa_b, pa_b, we_b, bs_b, dn_b, ov_b);
    end
  end

  // Move into the next cycle; inputs driven after this are sampled at its end.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    int nd_a, nd_b, nw_a, nw_b;
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; rgbfilter_in = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_busy", 0, int'(bs_a), 0);
    chk("lit_rst_we", 1, int'(we_b), 0);
    chk("lit_rst_orig", 0, int'(oa_a), 0);

    // Basic frame, latency sweep and filter stability.
    step(); enable = 1'b1; frame_start = 1'b1; rgbfilter_in = 3'b100;
    for (int j = 1; j <= 21; j++) begin
      step(); frame_start = 1'b0;
      if (j == 5) rgbfilter_in = 3'b011;
      @(negedge clk);
      case (j)
        1:  begin chk("lit_orig0", 0, int'(oa_a), 0); chk("lit_filt", 0, int'(rgb_a), 4);
                  chk("lit_we_early", 0, int'(we_a), 0); end
        2:  begin chk("lit_we_first", 0, int'(we_a), 1); chk("lit_pa_first", 0, int'(pa_a), 0); end
        3:  chk("lit_we_lat3_early", 1, int'(we_b), 0);
        4:  begin chk("lit_we_lat3", 1, int'(we_b), 1); chk("lit_pa_lat3", 1, int'(pa_b), 0); end
        16: chk("lit_orig_last", 0, int'(oa_a), 15);
        17: begin chk("lit_pa_last", 0, int'(pa_a), 15); chk("lit_filt_hold", 0, int'(rgb_a), 4);
                  chk("lit_done_early", 0, int'(dn_a), 0); end
        18: begin chk("lit_done", 0, int'(dn_a), 1); chk("lit_we_after", 0, int'(we_a), 0);
                  chk("lit_busy_done", 0, int'(bs_a), 1); end
        19: begin chk("lit_idle", 0, int'(bs_a), 0); chk("lit_pa_last_lat3", 1, int'(pa_b), 15);
                  chk("lit_filt_hold_lat3", 1, int'(rgb_b), 4); end
        20: chk("lit_done_lat3", 1, int'(dn_b), 1);
        21: chk("lit_idle_lat3", 1, int'(bs_b), 0);
        default: ;
      endcase
    end
    step(); frame_start = 1'b1;
    step(); frame_start = 1'b0;
    @(negedge clk);
    chk("lit_filt_new", 0, int'(rgb_a), 3);
    chk("lit_filt_new", 1, int'(rgb_b), 3);
    repeat (25) step();

    // Overrun: two starts during RUN collapse into one extra frame.
    nd_a = 0; nd_b = 0;
    step(); frame_start = 1'b1; rgbfilter_in = 3'b001;
    for (int j = 1; j <= 45; j++) begin
      step(); frame_start = (j == 3 || j == 8);
      @(negedge clk);
      nd_a += int'(dn_a); nd_b += int'(dn_b);
      if (j == 3 || j == 8) begin
        chk("lit_overrun", 0, int'(ov_a), 1); chk("lit_overrun", 1, int'(ov_b), 1);
      end
      if (j == 4) chk("lit_overrun_off", 0, int'(ov_a), 0);
      if (j == 19) chk("lit_gap_idle", 0, int'(bs_a), 0);
      if (j == 20) begin chk("lit_restart", 0, int'(bs_a), 1); chk("lit_restart_orig", 0, int'(oa_a), 0); end
    end
    chk("lit_done_count", 0, nd_a, 2);
    chk("lit_done_count", 1, nd_b, 2);

    // Enable gating.
    step(); enable = 1'b0; frame_start = 1'b1;
    step(); frame_start = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("lit_gated_idle", 0, int'(bs_a), 0);
    chk("lit_gated_idle", 1, int'(bs_b), 0);
    nd_a = 0; nd_b = 0;
    step(); enable = 1'b1; frame_start = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step(); frame_start = (j == 3); enable = (j != 3);
      @(negedge clk);
      nd_a += int'(dn_a); nd_b += int'(dn_b);
      if (j == 3) chk("lit_gated_ovr", 0, int'(ov_a), 0);
      if (j == 25) chk("lit_no_second", 0, int'(bs_a), 0);
    end
    chk("lit_gated_done", 0, nd_a, 1);
    chk("lit_gated_done", 1, nd_b, 1);

    // Reset mid-frame at orig_addr 7.
    nd_a = 0;
    step(); frame_start = 1'b1; rgbfilter_in = 3'b110;
    for (int j = 1; j <= 12; j++) begin
      step(); frame_start = 1'b0; rst = (j == 8);
      @(negedge clk);
      nd_a += int'(dn_a);
      if (j == 8) chk("lit_mid_orig", 0, int'(oa_a), 7);
      if (j == 9) begin
        chk("lit_abort_busy", 0, int'(bs_a), 0); chk("lit_abort_we", 0, int'(we_a), 0);
        chk("lit_abort_orig", 0, int'(oa_a), 0); chk("lit_abort_filt", 0, int'(rgb_a), 0);
        chk("lit_abort_we", 1, int'(we_b), 0); chk("lit_abort_pa", 1, int'(pa_b), 0);
      end
    end
    chk("lit_abort_no_done", 0, nd_a, 0);
    nw_a = 0; nw_b = 0;
    step(); frame_start = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      step(); frame_start = 1'b0;
      @(negedge clk);
      nw_a += int'(we_a); nw_b += int'(we_b);
    end
    chk("lit_write_count", 0, nw_a, 16);
    chk("lit_write_count", 1, nw_b, 16);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      frame_start  = ($urandom_range(0, 15) == 0);
      enable       = ($urandom_range(0, 7) != 0);
      rgbfilter_in = 3'($urandom);
      rst          = ($urandom_range(0, 499) == 0);
    end
    step(); frame_start = 1'b0; rst = 1'b0;
    repeat (30) step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
